// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU select codes, FSM states, flag indices and decode record
package alu_pkg;

  localparam logic [3:0] SEL_INC = 4'h0;
  localparam logic [3:0] SEL_DEC = 4'h1;
  localparam logic [3:0] SEL_ADD = 4'h2;
  localparam logic [3:0] SEL_ADC = 4'h3;
  localparam logic [3:0] SEL_SUB = 4'h4;
  localparam logic [3:0] SEL_SBB = 4'h5;
  localparam logic [3:0] SEL_AND = 4'h6;
  localparam logic [3:0] SEL_XOR = 4'h7;
  localparam logic [3:0] SEL_OR  = 4'h8;
  localparam logic [3:0] SEL_RLC = 4'h9;
  localparam logic [3:0] SEL_RAL = 4'hA;
  localparam logic [3:0] SEL_RRC = 4'hB;
  localparam logic [3:0] SEL_RAR = 4'hC;
  localparam logic [3:0] SEL_CMA = 4'hD;
  localparam logic [3:0] SEL_CMC = 4'hE;
  localparam logic [3:0] SEL_STC = 4'hF;

  localparam int FLAG_Z  = 3;
  localparam int FLAG_S  = 2;
  localparam int FLAG_P  = 1;
  localparam int FLAG_CY = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_WRITE
  } state_e;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] flag_mask;
    logic       clr_cy;
    logic       wr;
    logic [2:0] dest;
    logic       illegal;
  } decode_t;

  localparam decode_t DEC_RESET = '{
    sel: SEL_INC, flag_mask: 4'b0000, clr_cy: 1'b0, wr: 1'b0, dest: 3'd7, illegal: 1'b0
  };

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational 8080 opcode to ALU select / flag mask decode
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [7:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = '{sel: SEL_INC, flag_mask: 4'b0000, clr_cy: 1'b0, wr: 1'b1, dest: 3'd7, illegal: 1'b0};
    // Register-source and immediate-source arithmetic share the same op field.
    if (opcode[7:6] == 2'b10 || (opcode[7:6] == 2'b11 && opcode[2:0] == 3'b110)) begin
      dec.flag_mask = 4'b1111;
      case (opcode[5:3])
        3'd0:    dec.sel = SEL_ADD;
        3'd1:    dec.sel = SEL_ADC;
        3'd2:    dec.sel = SEL_SUB;
        3'd3:    dec.sel = SEL_SBB;
        3'd4:    begin dec.sel = SEL_AND; dec.clr_cy = 1'b1; end
        3'd5:    begin dec.sel = SEL_XOR; dec.clr_cy = 1'b1; end
        3'd6:    begin dec.sel = SEL_OR;  dec.clr_cy = 1'b1; end
        default: begin dec.sel = SEL_SUB; dec.wr = 1'b0; end
      endcase
    end else if (opcode[7:6] == 2'b00 && opcode[2:1] == 2'b10) begin
      dec.sel       = opcode[0] ? SEL_DEC : SEL_INC;
      dec.flag_mask = 4'b1110;
      dec.dest      = opcode[5:3];
    end else begin
      case (opcode)
        8'h07:   begin dec.sel = SEL_RLC; dec.flag_mask = 4'b0001; end
        8'h0F:   begin dec.sel = SEL_RRC; dec.flag_mask = 4'b0001; end
        8'h17:   begin dec.sel = SEL_RAL; dec.flag_mask = 4'b0001; end
        8'h1F:   begin dec.sel = SEL_RAR; dec.flag_mask = 4'b0001; end
        8'h2F:   dec.sel = SEL_CMA;
        8'h37:   begin dec.sel = SEL_STC; dec.flag_mask = 4'b0001; dec.wr = 1'b0; end
        8'h3F:   begin dec.sel = SEL_CMC; dec.flag_mask = 4'b0001; dec.wr = 1'b0; end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 8080 ALU control sequencer: operand latch, ALU handshake, flag register
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         op_valid_i,
  output logic         op_ready_o,
  input  logic [7:0]   opcode_i,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] src_dat_i,
  output logic [W-1:0] a_dat_o,
  output logic [W-1:0] b_dat_o,
  output logic [3:0]   alu_sel_o,
  output logic         alu_out_o,
  output logic         flag_out_o,
  output logic         carry_o,
  input  logic [W-1:0] alu_dat_i,
  input  logic [3:0]   flag_i,
  output logic [W-1:0] result_o,
  output logic         res_valid_o,
  output logic         res_wr_o,
  output logic [2:0]   dest_sel_o,
  output logic         illegal_o,
  output logic [3:0]   flags_o
);

  state_e       state_q, state_d;
  decode_t      dec, dec_q;
  logic [W-1:0] act_q, tmp_q, result_q;
  logic [3:0]   flags_q, raw_flags, flags_d;
  logic         accept;

  alu_op_decode u_decode (
    .opcode (opcode_i),
    .dec    (dec)
  );

  assign op_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign accept     = op_valid_i && op_ready_o;
  assign a_dat_o    = act_q;
  assign b_dat_o    = tmp_q;
  assign alu_sel_o  = dec_q.sel;
  assign dest_sel_o = dec_q.dest;
  assign result_o   = result_q;
  assign flags_o    = flags_q;
  assign carry_o    = flags_q[FLAG_CY];

  always_comb begin
    state_d     = state_q;
    alu_out_o   = 1'b0;
    flag_out_o  = 1'b0;
    res_valid_o = 1'b0;
    res_wr_o    = 1'b0;
    illegal_o   = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      // Unsupported opcodes spend their LOAD cycle signalling and skip the ALU.
      ST_LOAD: begin
        illegal_o = dec_q.illegal;
        state_d   = dec_q.illegal ? ST_IDLE : ST_EXEC;
      end
      ST_EXEC: begin
        alu_out_o  = 1'b1;
        flag_out_o = 1'b1;
        state_d    = ST_WRITE;
      end
      default: begin
        res_valid_o = 1'b1;
        res_wr_o    = dec_q.wr;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    raw_flags          = 4'b0000;
    raw_flags[FLAG_Z]  = ~flag_i[3];
    raw_flags[FLAG_S]  = flag_i[2];
    raw_flags[FLAG_P]  = ~flag_i[1];
    raw_flags[FLAG_CY] = flag_i[0];
    flags_d = (dec_q.flag_mask & raw_flags) | (~dec_q.flag_mask & flags_q);
    if (dec_q.clr_cy) flags_d[FLAG_CY] = 1'b0;
    // STC/CMC define the carry themselves; the ALU carry output is ignored.
    if (dec_q.sel == SEL_STC)      flags_d[FLAG_CY] = 1'b1;
    else if (dec_q.sel == SEL_CMC) flags_d[FLAG_CY] = ~flags_q[FLAG_CY];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      dec_q    <= DEC_RESET;
      act_q    <= '0;
      tmp_q    <= '0;
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dec_q <= dec;
        act_q <= acc_i;
        tmp_q <= src_dat_i;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_dat_i;
        flags_q  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized and directed bench for alu_sequencer with an 8080-level model
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       op_valid_i = 1'b0;
  logic [7:0] opcode_i = 8'h00;
  logic [7:0] acc_i = 8'h00;
  logic [7:0] src_dat_i = 8'h00;
  logic       op_ready_o, alu_out_o, flag_out_o, carry_o;
  logic       res_valid_o, res_wr_o, illegal_o;
  logic [7:0] a_dat_o, b_dat_o, alu_dat_i, result_o;
  logic [3:0] alu_sel_o, flag_i, flags_o;
  logic [2:0] dest_sel_o;
  logic [8:0] alu_t;

  int vectors = 0;
  int miscompares = 0;

  alu_sequencer #(.W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .opcode_i(opcode_i), .acc_i(acc_i), .src_dat_i(src_dat_i),
    .a_dat_o(a_dat_o), .b_dat_o(b_dat_o), .alu_sel_o(alu_sel_o),
    .alu_out_o(alu_out_o), .flag_out_o(flag_out_o), .carry_o(carry_o),
    .alu_dat_i(alu_dat_i), .flag_i(flag_i), .result_o(result_o),
    .res_valid_o(res_valid_o), .res_wr_o(res_wr_o), .dest_sel_o(dest_sel_o),
    .illegal_o(illegal_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  // ALU stand-in: only drives its outputs while the sequencer enables them.
  always_comb begin
    alu_t = 9'd0;
    case (alu_sel_o)
      4'h0: alu_t = {1'b0, b_dat_o} + 9'd1;
      4'h1: alu_t = {1'b0, b_dat_o} - 9'd1;
      4'h2: alu_t = {1'b0, a_dat_o} + {1'b0, b_dat_o};
      4'h3: alu_t = {1'b0, a_dat_o} + {1'b0, b_dat_o} + {8'd0, carry_o};
      4'h4: alu_t = {1'b0, a_dat_o} - {1'b0, b_dat_o};
      4'h5: alu_t = {1'b0, a_dat_o} - {1'b0, b_dat_o} - {8'd0, carry_o};
      4'h6: alu_t = {1'b0, a_dat_o & b_dat_o};
      4'h7: alu_t = {1'b0, a_dat_o ^ b_dat_o};
      4'h8: alu_t = {1'b0, a_dat_o | b_dat_o};
      4'h9: alu_t = {a_dat_o[7], a_dat_o[6:0], a_dat_o[7]};
      4'hA: alu_t = {a_dat_o[7], a_dat_o[6:0], carry_o};
      4'hB: alu_t = {a_dat_o[0], a_dat_o[0], a_dat_o[7:1]};
      4'hC: alu_t = {a_dat_o[0], carry_o, a_dat_o[7:1]};
      4'hD: alu_t = {1'b0, ~a_dat_o};
      default: alu_t = {1'b0, a_dat_o};
    endcase
    alu_dat_i = alu_out_o ? alu_t[7:0] : 8'h00;
    flag_i    = flag_out_o ? {|alu_t[7:0], alu_t[7], ^alu_t[7:0], alu_t[8]} : 4'h0;
  end

  typedef struct packed {
    logic       ill;
    logic [3:0] sel;
    logic [7:0] r;
    logic [3:0] f;
    logic       wr;
    logic [2:0] dst;
  } exp_t;

  function automatic logic [3:0] zsp(input logic [7:0] r, input logic cy);
    return {r == 8'h00, r[7], ~^r, cy};
  endfunction

  // 8080 instruction semantics; f is {Z,S,P,CY} before the op.
  function automatic exp_t model_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] s,
                                    input logic [3:0] f);
    exp_t e;
    logic [8:0] t;
    logic c;
    c = f[0];
    e = '{ill: 1'b0, sel: 4'h0, r: a, f: f, wr: 1'b1, dst: 3'd7};
    if (op[7:6] == 2'b10 || (op[7:6] == 2'b11 && op[2:0] == 3'b110)) begin
      case (op[5:3])
        3'd0: begin t = {1'b0, a} + {1'b0, s};               e.sel = 4'h2; end
        3'd1: begin t = {1'b0, a} + {1'b0, s} + {8'd0, c};   e.sel = 4'h3; end
        3'd2: begin t = {1'b0, a} - {1'b0, s};               e.sel = 4'h4; end
        3'd3: begin t = {1'b0, a} - {1'b0, s} - {8'd0, c};   e.sel = 4'h5; end
        3'd4: begin t = {1'b0, a & s};                       e.sel = 4'h6; end
        3'd5: begin t = {1'b0, a ^ s};                       e.sel = 4'h7; end
        3'd6: begin t = {1'b0, a | s};                       e.sel = 4'h8; end
        default: begin t = {1'b0, a} - {1'b0, s}; e.sel = 4'h4; e.wr = 1'b0; end
      endcase
      e.r = t[7:0];
      e.f = zsp(t[7:0], t[8]);
    end else if (op[7:6] == 2'b00 && op[2:1] == 2'b10) begin
      e.r   = op[0] ? s - 8'd1 : s + 8'd1;
      e.sel = {3'b000, op[0]};
      e.f   = zsp(e.r, c);
      e.dst = op[5:3];
    end else begin
      case (op)
        8'h07: begin e.r = {a[6:0], a[7]}; e.f[0] = a[7]; e.sel = 4'h9; end
        8'h0F: begin e.r = {a[0], a[7:1]}; e.f[0] = a[0]; e.sel = 4'hB; end
        8'h17: begin e.r = {a[6:0], c};    e.f[0] = a[7]; e.sel = 4'hA; end
        8'h1F: begin e.r = {c, a[7:1]};    e.f[0] = a[0]; e.sel = 4'hC; end
        8'h2F: begin e.r = ~a; e.sel = 4'hD; end
        8'h37: begin e.f[0] = 1'b1; e.wr = 1'b0; e.sel = 4'hF; end
        8'h3F: begin e.f[0] = ~c;   e.wr = 1'b0; e.sel = 4'hE; end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: cycles since accept (0 = idle), plus architectural flags/result.
  int         ph = 0;
  exp_t       pend = '0;
  logic [7:0] pa = 8'h00, pb = 8'h00, mres = 8'h00;
  logic [3:0] mflags = 4'h0;

  always @(posedge clk) begin
    if (rst_i) begin
      ph <= 0; mflags <= 4'h0; mres <= 8'h00;
    end else begin
      case (ph)
        0: if (op_valid_i) begin
             pend <= model_op(opcode_i, acc_i, src_dat_i, mflags);
             pa <= acc_i; pb <= src_dat_i; ph <= 1;
           end
        1: ph <= pend.ill ? 0 : 2;
        2: begin ph <= 3; mflags <= pend.f; mres <= pend.r; end
        default: ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("op_ready", op_ready_o, (ph == 0) && !rst_i);
    chk("res_valid", res_valid_o, ph == 3);
    chk("illegal", illegal_o, (ph == 1) && pend.ill);
    chk("alu_out", {alu_out_o, flag_out_o}, (ph == 2) ? 2'b11 : 2'b00);
    chk("flags", flags_o, mflags);
    chk("carry", carry_o, mflags[0]);
    chk("result", result_o, mres);
    if (ph == 3) begin
      chk("res_wr", res_wr_o, pend.wr);
      chk("dest_sel", dest_sel_o, pend.dst);
    end
    if ((ph == 1 || ph == 2) && !pend.ill) begin
      chk("a_dat", a_dat_o, pa);
      chk("b_dat", b_dat_o, pb);
      chk("alu_sel", alu_sel_o, pend.sel);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!op_ready_o && k < 10) begin step(); k++; end
    if (k == 10) chk("idle_timeout", op_ready_o, 1);
  endtask

  task automatic issue(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] s);
    wait_idle();
    op_valid_i = 1'b1; opcode_i = opc; acc_i = a; src_dat_i = s;
    step();
    op_valid_i = 1'b0;
  endtask

  // Returns with the bench sitting in the result cycle; lat counts cycles after accept.
  task automatic run_op(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] s,
                        output int lat);
    issue(opc, a, s);
    lat = 1;
    while (!res_valid_o && lat < 8) begin step(); lat++; end
  endtask

  logic [7:0] specials [7] = '{8'h07, 8'h0F, 8'h17, 8'h1F, 8'h2F, 8'h37, 8'h3F};

  initial begin
    int lat, last, n, seen;
    logic [7:0] opc;
    repeat (3) step();
    chk("rst_flags", flags_o, 4'h0);
    chk("rst_dest", dest_sel_o, 3'd7);
    chk("rst_sel", alu_sel_o, 4'h0);
    chk("rst_a_dat", a_dat_o, 8'h00);
    rst_i = 1'b0;
    step();

    run_op(8'h80, 8'h3A, 8'hC6, lat);
    chk("add_latency", lat, 3);
    chk("add_result", result_o, 8'h00);
    chk("add_flags", flags_o, 4'b1011);
    chk("add_wr", {res_wr_o, dest_sel_o}, {1'b1, 3'd7});

    run_op(8'hB8, 8'h05, 8'h07, lat);
    chk("cmp_result", result_o, 8'hFE);
    chk("cmp_flags", flags_o, 4'b0101);
    chk("cmp_wr", res_wr_o, 1'b0);

    run_op(8'h04, 8'h11, 8'hFF, lat);
    chk("inr_result", result_o, 8'h00);
    chk("inr_dest", dest_sel_o, 3'd0);
    chk("inr_flags", flags_o, 4'b1011);

    run_op(8'hA0, 8'hF0, 8'h0F, lat);
    chk("ana_result", result_o, 8'h00);
    chk("ana_flags", flags_o, 4'b1010);

    run_op(8'h37, 8'h00, 8'h00, lat);
    chk("stc_flags", flags_o, 4'b1011);
    chk("stc_wr", res_wr_o, 1'b0);

    run_op(8'h17, 8'h80, 8'h00, lat);
    chk("ral_result", result_o, 8'h01);
    chk("ral_flags", flags_o, 4'b1011);

    issue(8'h00, 8'h55, 8'hAA);
    chk("ill_pulse", {illegal_o, res_valid_o}, 2'b10);
    step();
    chk("ill_done", {illegal_o, op_ready_o}, 2'b01);
    seen = 0;
    repeat (4) begin step(); if (res_valid_o) seen++; end
    chk("ill_no_result", seen, 0);
    chk("ill_flags", flags_o, 4'b1011);

    wait_idle();
    op_valid_i = 1'b1; opcode_i = 8'h80; acc_i = 8'h12; src_dat_i = 8'h34;
    last = -1; n = 0;
    for (int c = 0; c < 14; c++) begin
      if (op_ready_o) begin
        if (last >= 0) chk("accept_gap", c - last, 4);
        last = c; n++;
      end
      step();
    end
    op_valid_i = 1'b0;
    chk("accept_count", n, 4);

    issue(8'h88, 8'h01, 8'h02);
    step();
    chk("rst_exec", alu_out_o, 1'b1);
    rst_i = 1'b1;
    step();
    chk("rst_abort", {res_valid_o, op_ready_o, flags_o}, {1'b0, 1'b0, 4'h0});
    rst_i = 1'b0;
    step();
    chk("rst_ready", op_ready_o, 1'b1);

    for (int i = 0; i < 400; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
      case ($urandom_range(0, 4))
        0: opc = 8'($urandom);
        1: opc = {2'b10, 6'($urandom)};
        2: opc = specials[$urandom_range(0, 6)];
        3: opc = {2'b00, 3'($urandom), 2'b10, 1'($urandom)};
        default: opc = {2'b11, 3'($urandom), 3'b110};
      endcase
      issue(opc, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(0, 2)) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
      end
    end
    wait_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control-side initiator for the 8080 ALU datapath. Accepts one arithmetic, logic, rotate or carry opcode with its operands and drives the ALU select, operand and output-enable lines. Captures the ALU result and raw flags, and updates the architectural flag register {Z,S,P,CY} under per-opcode flag masks. Sits between the instruction decoder/register file and the ALU, and feeds the stored carry back to the ALU.

Parameters:
W, 8, data width; the opcode decode is 8080-specific, so only W=8 is supported.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
op_valid_i  in  1  opcode and operands present
op_ready_o  out  1  block idle, accepts when op_valid_i & op_ready_o
opcode_i  in  8  8080 opcode
acc_i  in  8  accumulator value
src_dat_i  in  8  register, memory or immediate operand
a_dat_o  out  8  ALU operand A (latched ACT)
b_dat_o  out  8  ALU operand B (latched TMP)
alu_sel_o  out  4  ALU function select
alu_out_o  out  1  ALU result output enable
flag_out_o  out  1  ALU flag output enable
carry_o  out  1  stored CY, ALU carry-in
alu_dat_i  in  8  ALU result
flag_i  in  4  raw ALU flags {nz, s, par_odd, cy}
result_o  out  8  captured result
res_valid_o  out  1  one-cycle result strobe
res_wr_o  out  1  with res_valid_o: write result_o to dest_sel_o
dest_sel_o  out  3  8080 register code (7 = A)
illegal_o  out  1  one-cycle unsupported-opcode strobe
flags_o  out  4  flag register {Z,S,P,CY}

Behaviour:
- Reset: state IDLE; flags_o=0; result_o=0; a_dat_o=b_dat_o=0; alu_sel_o=0; alu_out_o=flag_out_o=res_valid_o=res_wr_o=illegal_o=0; dest_sel_o=7.
- op_ready_o = (state==IDLE) & !rst_i.
- FSM: IDLE -> LOAD -> EXEC -> WRITE -> IDLE.
  - IDLE: on accept, latch opcode, acc_i into ACT and src_dat_i into TMP.
  - LOAD: a_dat_o=ACT, b_dat_o=TMP, alu_sel_o valid.
  - EXEC: alu_out_o=flag_out_o=1; sample alu_dat_i and flag_i at the end of EXEC.
  - WRITE: result_o holds the sample; res_valid_o=1; flags_o updated on the same edge.
- Latency: accept edge at cycle 0, res_valid_o high in cycle 3. Maximum throughput is one op per 4 cycles; no accept outside IDLE.
- INC/DEC place src_dat_i on b_dat_o. All other ops use ACT on a_dat_o and TMP on b_dat_o.
- Decode (ALU select codes INC=0 .. STC=F):
  - 10xxxsss and 11xxx110 (ADD/ADC/SUB/SBB/ANA/XRA/ORA/CMP): sel 2,3,4,5,6,7,8,4. Flags Z,S,P,CY. ANA/XRA/ORA force CY=0. CMP gives res_wr_o=0.
  - 00ddd100 INR (sel 0) and 00ddd101 DCR (sel 1): dest_sel_o=ddd; Z,S,P updated; CY preserved.
  - 07 RLC, 0F RRC, 17 RAL, 1F RAR: sel 9, B, A, C; CY only.
  - 2F CMA: sel D; no flags.
  - 37 STC, 3F CMC: sel F, E; CY only; res_wr_o=0.
  - Any other opcode: no ALU cycle. Next cycle illegal_o=1; state returns to IDLE; flags and result unchanged.
- Flag conversion: Z=~nz, S=s, P=~par_odd (even parity -> P=1), CY=cy. STC forces CY=1; CMC forces CY=~CY, independent of the ALU flag output.
- carry_o = flags_o[0] continuously.
- dest_sel_o=7 for every op except INR/DCR.
- rst_i in any state aborts the op: no res_valid_o, registers go to reset values.

Decomposition:
- Package alu_pkg: the 4-bit ALU select constants, the FSM state enum, the flag index constants (Z=3, S=2, P=1, CY=0) and a decode struct {sel, flag_mask, clr_cy, wr, dest, illegal}.
- Sub-module alu_op_decode: purely combinational, opcode -> decode struct. Registered by the FSM at accept.

Test Plan:
- ADD (0x80): acc 0x3A, src 0xC6, ALU model in bench -> res_valid_o in cycle 3; result_o=0x00; flags_o=4'b1011; res_wr_o=1; dest_sel_o=7.
- CMP (0xB8): acc 0x05, src 0x07 -> result_o=0xFE; res_wr_o=0; flags_o=4'b0101; accumulator is not written.
- INR B (0x04) with CY=1: src 0xFF -> result_o=0x00; dest_sel_o=0; flags_o=4'b1011 (CY preserved); then ANA (0xA0) acc 0xF0, src 0x0F -> result 0x00, CY=0.
- STC (0x37) then RAL (0x17) with acc 0x80: STC sets CY=1; RAL gives result_o=0x01, CY=1, Z/S/P unchanged from before.
- Illegal opcode 0x00: illegal_o pulses for one cycle after accept; no res_valid_o; flags_o unchanged. Also hold op_valid_i high: accepts occur every 4 cycles exactly.
- Reset asserted during EXEC of ADC: no res_valid_o; flags_o=0; op_ready_o=1 the cycle after rst_i falls.
